fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 19-bit pipelined CPU. It tracks destination-register information for the instructions in EX, MEM and WB, and drives the 2-bit select of each ALU operand forwarding mux (A and B). It also detects load-use hazards, stalls IF/ID while inserting one EX bubble, and honours branch flushes. It sits beside the ID/EX pipeline registers and is fed with decode fields from ID.

---
 rtl/fwd_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 19-bit pipelined CPU.
// Tracks EX/MEM/WB destination info, drives the operand forwarding mux selects, and handles stalls and flushes.
module fwd_hazard_ctrl #(
  parameter int REG_AW   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  logic              ex_valid, ex_use1, ex_use2, ex_we, ex_load;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_valid, mem_we, mem_load;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_we;
  logic [REG_AW-1:0] wb_rd;

  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b, load_use;

  // A stage is a producer of register r only if it really writes r; r0 never counts when hardwired.
  function automatic logic hits(input logic v, input logic we,
                                input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
    return v && we && (rd == r) && (!ZERO_REG || (rd != '0));
  endfunction

  always_comb begin
    mem_hit_a = ex_valid && ex_use1 && !mem_load && hits(mem_valid, mem_we, mem_rd, ex_rs1);
    wb_hit_a  = ex_valid && ex_use1 && hits(wb_valid, wb_we, wb_rd, ex_rs1);
    mem_hit_b = ex_valid && ex_use2 && !mem_load && hits(mem_valid, mem_we, mem_rd, ex_rs2);
    wb_hit_b  = ex_valid && ex_use2 && hits(wb_valid, wb_we, wb_rd, ex_rs2);
    fwd_sel_a = mem_hit_a ? 2'b01 : (wb_hit_a ? 2'b10 : 2'b00);
    fwd_sel_b = mem_hit_b ? 2'b01 : (wb_hit_b ? 2'b10 : 2'b00);
    load_use  = ex_load && ((id_use_rs1 && hits(ex_valid, ex_we, ex_rd, id_rs1)) ||
                            (id_use_rs2 && hits(ex_valid, ex_we, ex_rd, id_rs2)));
    stall     = !flush && id_valid && load_use;
  end

  // MEM and WB always advance; EX is squashed on flush, bubbled on stall, else loaded from ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_use1   <= 1'b0;
      ex_use2   <= 1'b0;
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      ex_bubble <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      mem_load  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
    end else begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      mem_load  <= ex_load;
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_we     <= mem_we;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_use1   <= id_use_rs1;
      ex_use2   <= id_use_rs2;
      ex_rd     <= id_rd;
      ex_we     <= id_rd_we;
      ex_load   <= id_is_load;
      if (flush) begin
        ex_valid  <= 1'b0;
        ex_bubble <= 1'b0;
      end else if (stall) begin
        ex_valid  <= 1'b0;
        ex_bubble <= 1'b1;
      end else begin
        ex_valid  <= id_valid;
        ex_bubble <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked every cycle against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_rd_we, id_is_load, flush, cnt_clr;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_sel_a, fwd_sel_b, fwd_sel_a4, fwd_sel_b4;
  logic       stall, ex_bubble, stall4, ex_bubble4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall(stall), .ex_bubble(ex_bubble), .stall_count(stall_count)
  );

  // Narrow-counter copy on the same inputs so counter saturation is reachable quickly.
  fwd_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr), .fwd_sel_a(fwd_sel_a4),
    .fwd_sel_b(fwd_sel_b4), .stall(stall4), .ex_bubble(ex_bubble4), .stall_count(stall_count4)
  );

  typedef struct {
    bit       v;
    bit [2:0] rs1;
    bit [2:0] rs2;
    bit       u1;
    bit       u2;
    bit [2:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe [3];
  instr_t cur;
  bit     m_bubble, m_stalled, m_s;
  int     m_cnt, m_cnt4;
  int     errors = 0;
  int     checks = 0;
  bit     check_en = 1'b0;

  function automatic bit produces(input instr_t p, input bit [2:0] r);
    return p.v && p.we && (p.rd == r) && (p.rd != 3'd0);
  endfunction

  // Youngest real producer wins, but a load still in MEM has no data yet.
  function automatic int exp_fwd(input bit [2:0] r, input bit use_r);
    if (!pipe[0].v || !use_r) return 0;
    if (produces(pipe[1], r) && !pipe[1].ld) return 1;
    if (produces(pipe[2], r)) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (flush || !id_valid || !pipe[0].ld) return 1'b0;
    return (id_use_rs1 && produces(pipe[0], id_rs1)) || (id_use_rs2 && produces(pipe[0], id_rs2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      m_bubble  = 1'b0;
      m_stalled = 1'b0;
      m_cnt     = 0;
      m_cnt4    = 0;
    end else begin
      m_s = exp_stall();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (flush) begin
        pipe[0] = '{default: 0};
        m_bubble = 1'b0;
      end else if (m_s) begin
        pipe[0] = '{default: 0};
        m_bubble = 1'b1;
      end else begin
        pipe[0] = '{id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we, id_is_load};
        m_bubble = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt = 0;
        m_cnt4 = 0;
      end else if (m_s) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_stalled = m_s;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("fwd_sel_a", int'(fwd_sel_a), exp_fwd(pipe[0].rs1, pipe[0].u1));
      checkOutput("fwd_sel_b", int'(fwd_sel_b), exp_fwd(pipe[0].rs2, pipe[0].u2));
      checkOutput("stall", int'(stall), int'(exp_stall()));
      checkOutput("ex_bubble", int'(ex_bubble), int'(m_bubble));
      checkOutput("stall_count", int'(stall_count), m_cnt);
      checkOutput("stall_count_sat", int'(stall_count4), m_cnt4);
    end
  end

  task automatic drive(input instr_t i, input bit fl, input bit clr);
    id_valid   = i.v;
    id_rs1     = i.rs1;
    id_rs2     = i.rs2;
    id_use_rs1 = i.u1;
    id_use_rs2 = i.u2;
    id_rd      = i.rd;
    id_rd_we   = i.we;
    id_is_load = i.ld;
    flush      = fl;
    cnt_clr    = clr;
  endtask

  task automatic applyStimulus(input bit v, input bit [2:0] rs1, input bit u1, input bit [2:0] rs2,
                               input bit u2, input bit [2:0] rd, input bit we, input bit ld,
                               input bit fl = 1'b0, input bit clr = 1'b0);
    instr_t i;
    i = '{v, rs1, rs2, u1, u2, rd, we, ld};
    @(posedge clk);
    #1;
    drive(i, fl, clr);
  endtask

  task automatic nop(input bit clr = 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, clr);
  endtask

  initial begin
    rst = 1'b1;
    drive('{default: 0}, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_fwd_a", int'(fwd_sel_a), 0);
    checkOutput("reset_stall", int'(stall), 0);
    checkOutput("reset_count", int'(stall_count), 0);
    #2 rst = 1'b0;
    check_en = 1'b1;

    // ADD r3 then SUB r3 as rs1: forward from MEM on A only
    applyStimulus(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0);
    applyStimulus(1, 3'd3, 1, 3'd4, 1, 3'd5, 1, 0);
    nop();
    @(negedge clk);
    checkOutput("b2b_fwd_a", int'(fwd_sel_a), 1);
    checkOutput("b2b_fwd_b", int'(fwd_sel_b), 0);

    // ADD r5, NOP, AND r5 as rs2: forward from WB on B
    applyStimulus(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0);
    nop();
    applyStimulus(1, 3'd1, 1, 3'd5, 1, 3'd6, 1, 0);
    nop();
    @(negedge clk);
    checkOutput("dist2_fwd_b", int'(fwd_sel_b), 2);
    checkOutput("dist2_fwd_a", int'(fwd_sel_a), 0);

    // r5 written in both MEM and WB: youngest (MEM) wins
    applyStimulus(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0);
    applyStimulus(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0);
    applyStimulus(1, 3'd1, 1, 3'd5, 1, 3'd6, 1, 0);
    nop();
    @(negedge clk);
    checkOutput("both_fwd_b", int'(fwd_sel_b), 1);

    // LD r2 then ADD r2: one stall, one bubble, then WB forward
    applyStimulus(1, 3'd6, 1, 3'd0, 0, 3'd2, 1, 1);
    applyStimulus(1, 3'd2, 1, 3'd7, 1, 3'd3, 1, 0);
    @(negedge clk);
    checkOutput("lu_stall", int'(stall), 1);
    applyStimulus(1, 3'd2, 1, 3'd7, 1, 3'd3, 1, 0);
    @(negedge clk);
    checkOutput("lu_stall_once", int'(stall), 0);
    checkOutput("lu_bubble", int'(ex_bubble), 1);
    nop();
    @(negedge clk);
    checkOutput("lu_fwd_a", int'(fwd_sel_a), 2);
    checkOutput("lu_count", int'(stall_count), 1);

    // Register 0 is never a forwarding source nor a load-use hazard
    applyStimulus(1, 3'd1, 1, 3'd2, 1, 3'd0, 1, 0);
    applyStimulus(1, 3'd0, 1, 3'd0, 1, 3'd4, 1, 0);
    nop();
    @(negedge clk);
    checkOutput("r0_fwd_a", int'(fwd_sel_a), 0);
    checkOutput("r0_fwd_b", int'(fwd_sel_b), 0);
    applyStimulus(1, 3'd1, 1, 3'd0, 0, 3'd0, 1, 1);
    applyStimulus(1, 3'd0, 1, 3'd0, 1, 3'd4, 1, 0);
    @(negedge clk);
    checkOutput("r0_load_stall", int'(stall), 0);

    // Flush beats a load-use hazard
    applyStimulus(1, 3'd1, 1, 3'd0, 0, 3'd4, 1, 1);
    applyStimulus(1, 3'd4, 1, 3'd0, 0, 3'd5, 1, 0, 1'b1);
    @(negedge clk);
    checkOutput("flush_stall", int'(stall), 0);
    nop();
    @(negedge clk);
    checkOutput("flush_bubble", int'(ex_bubble), 0);
    checkOutput("flush_count", int'(stall_count), 1);

    // Load chain on r1 saturates the narrow counter, then clear it
    nop(1'b1);
    repeat (40) applyStimulus(1, 3'd1, 1, 3'd0, 0, 3'd1, 1, 1);
    nop();
    @(negedge clk);
    checkOutput("sat_count", int'(stall_count4), 15);
    nop(1'b1);
    nop();
    @(negedge clk);
    checkOutput("clr_count_sat", int'(stall_count4), 0);
    checkOutput("clr_count", int'(stall_count), 0);

    // Asynchronous reset while stalled
    applyStimulus(1, 3'd6, 1, 3'd0, 0, 3'd2, 1, 1);
    applyStimulus(1, 3'd2, 1, 3'd7, 1, 3'd3, 1, 0);
    @(negedge clk);
    checkOutput("pre_rst_stall", int'(stall), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_stall", int'(stall), 0);
    checkOutput("rst_fwd_a", int'(fwd_sel_a), 0);
    checkOutput("rst_fwd_b", int'(fwd_sel_b), 0);
    checkOutput("rst_bubble", int'(ex_bubble), 0);
    checkOutput("rst_count", int'(stall_count), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Randomized traffic; a stalled ID instruction is held until it issues
    cur = '{default: 0};
    repeat (3000) begin
      @(posedge clk);
      #1;
      if (!m_stalled) begin
        cur.v   = ($urandom_range(0, 7) != 0);
        cur.rs1 = 3'($urandom_range(0, 3));
        cur.rs2 = 3'($urandom_range(0, 3));
        cur.u1  = ($urandom_range(0, 3) != 0);
        cur.u2  = ($urandom_range(0, 1) != 0);
        cur.rd  = 3'($urandom_range(0, 3));
        cur.we  = ($urandom_range(0, 4) != 0);
        cur.ld  = ($urandom_range(0, 2) == 0);
      end
      drive(cur, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end
    nop();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
